// File: rtl/t2mi_pkt_scheduler.sv
// Packet-order scheduler for the T2-MI packer: grants TS / L1-current / BB sources in frame order
// and keeps frame/superframe indices. Timestamp slot is compiled in only with T2MI_SCHED_TS_EN.
module t2mi_pkt_scheduler #(
  parameter int BBF_PER_FRAME = 8,
  parameter int FRAMES_PER_SF = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FRAME_START,
  input  logic       TS_REQ,
  input  logic       L1_REQ,
  input  logic       BB_REQ,
  input  logic       PKT_DONE,
  output logic [2:0] GRANT,
  output logic [7:0] PKT_TYPE,
  output logic [7:0] FRAME_IDX,
  output logic [3:0] SF_IDX,
  output logic       BUSY,
  output logic       ERR_OVERRUN,
  output logic       ERR_UNDERRUN
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_TS = 3'd1,
    S_SEND_TS = 3'd2,
    S_WAIT_L1 = 3'd3,
    S_SEND_L1 = 3'd4,
    S_WAIT_BB = 3'd5,
    S_SEND_BB = 3'd6
  } state_t;

`ifdef T2MI_SCHED_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
  logic unused_ts_req;
  assign unused_ts_req = TS_REQ;
`endif

  localparam logic [7:0] BBF_INIT   = 8'(BBF_PER_FRAME);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SF - 1);

  state_t     state_q, state_d;
  logic [7:0] bb_cnt_q, bb_cnt_d;
  logic       pending_q, pending_d;
  logic [7:0] frame_idx_q, frame_idx_d, frame_idx_adv;
  logic [3:0] sf_idx_q, sf_idx_d, sf_idx_adv;
  logic [2:0] grant_q, grant_d;
  logic [7:0] pkt_type_q, pkt_type_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;
  logic       und_q, und_d;
  logic       adv, restart, final_done;
  state_t     start_cur, start_adv;

  always_comb begin
    if (frame_idx_q == FRAME_LAST) begin
      frame_idx_adv = 8'd0;
      sf_idx_adv    = sf_idx_q + 4'd1;
    end else begin
      frame_idx_adv = frame_idx_q + 8'd1;
      sf_idx_adv    = sf_idx_q;
    end
    start_cur = (TS_EN && frame_idx_q == 8'd0)   ? S_WAIT_TS : S_WAIT_L1;
    start_adv = (TS_EN && frame_idx_adv == 8'd0) ? S_WAIT_TS : S_WAIT_L1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      bb_cnt_q    <= 8'd0;
      pending_q   <= 1'b0;
      frame_idx_q <= 8'd0;
      sf_idx_q    <= 4'd0;
      grant_q     <= 3'b000;
      pkt_type_q  <= 8'h00;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bb_cnt_q    <= bb_cnt_d;
      pending_q   <= pending_d;
      frame_idx_q <= frame_idx_d;
      sf_idx_q    <= sf_idx_d;
      grant_q     <= grant_d;
      pkt_type_q  <= pkt_type_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
    end
  end

  // A final BB PKT_DONE coinciding with FRAME_START is a clean handover, not an overrun.
  assign final_done = (state_q == S_SEND_BB) && PKT_DONE && (bb_cnt_q == 8'd1);

  always_comb begin
    state_d   = state_q;
    bb_cnt_d  = bb_cnt_q;
    pending_d = pending_q;
    adv       = 1'b0;
    restart   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (FRAME_START) begin
          state_d  = start_cur;
          bb_cnt_d = BBF_INIT;
        end
      end
`ifdef T2MI_SCHED_TS_EN
      S_WAIT_TS: begin
        if (FRAME_START) restart = 1'b1;
        else if (TS_REQ) state_d = S_SEND_TS;
      end
      S_SEND_TS: begin
        if (PKT_DONE) begin
          if (FRAME_START || pending_q) restart = 1'b1;
          else state_d = S_WAIT_L1;
        end else if (FRAME_START) pending_d = 1'b1;
      end
`endif
      S_WAIT_L1: begin
        if (FRAME_START) restart = 1'b1;
        else if (L1_REQ) state_d = S_SEND_L1;
      end
      S_SEND_L1: begin
        if (PKT_DONE) begin
          if (FRAME_START || pending_q) restart = 1'b1;
          else state_d = S_WAIT_BB;
        end else if (FRAME_START) pending_d = 1'b1;
      end
      S_WAIT_BB: begin
        if (FRAME_START) restart = 1'b1;
        else if (BB_REQ) state_d = S_SEND_BB;
      end
      S_SEND_BB: begin
        if (PKT_DONE) begin
          bb_cnt_d = bb_cnt_q - 8'd1;
          if (FRAME_START || pending_q) begin
            restart = 1'b1;
          end else if (bb_cnt_q == 8'd1) begin
            adv     = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_BB;
          end
        end else if (FRAME_START) pending_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Leftover slots of the old frame are dropped; new frame starts with fresh slot count.
    if (restart) begin
      adv       = 1'b1;
      state_d   = start_adv;
      bb_cnt_d  = BBF_INIT;
      pending_d = 1'b0;
    end
    frame_idx_d = adv ? frame_idx_adv : frame_idx_q;
    sf_idx_d    = adv ? sf_idx_adv : sf_idx_q;
  end

  always_comb begin
    grant_d = 3'b000;
    case (state_d)
`ifdef T2MI_SCHED_TS_EN
      S_SEND_TS: grant_d = 3'b100;
`endif
      S_SEND_L1: grant_d = 3'b010;
      S_SEND_BB: grant_d = 3'b001;
      default:   grant_d = 3'b000;
    endcase
    pkt_type_d = pkt_type_q;
    if (grant_q == 3'b000) begin
      if (grant_d == 3'b100) pkt_type_d = 8'h20;
      else if (grant_d == 3'b010) pkt_type_d = 8'h10;
      else if (grant_d == 3'b001) pkt_type_d = 8'h00;
    end
    busy_d = (state_d != S_IDLE);
    ovr_d  = FRAME_START && (state_q != S_IDLE) && !final_done;
    und_d  = ovr_d && ((state_q == S_WAIT_BB) || (state_q == S_SEND_BB));
  end

  assign GRANT        = grant_q;
  assign PKT_TYPE     = pkt_type_q;
  assign FRAME_IDX    = frame_idx_q;
  assign SF_IDX       = sf_idx_q;
  assign BUSY         = busy_q;
  assign ERR_OVERRUN  = ovr_q;
  assign ERR_UNDERRUN = und_q;

endmodule

// File: tb/tb_t2mi_pkt_scheduler.sv
// Directed bench for t2mi_pkt_scheduler (BBF_PER_FRAME=3, FRAMES_PER_SF=2); expectations follow T2MI_SCHED_TS_EN.
module tb_t2mi_pkt_scheduler;

  localparam int BBF = 3;
  localparam int FPS = 2;
`ifdef T2MI_SCHED_TS_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif

  logic       CLK, RST;
  logic       frame_start, ts_req, l1_req, bb_req, pkt_done;
  logic [2:0] GRANT;
  logic [7:0] PKT_TYPE, FRAME_IDX;
  logic [3:0] SF_IDX;
  logic       BUSY, ERR_OVERRUN, ERR_UNDERRUN;

  int checks = 0;
  int failures = 0;
  int m_idx = 0;
  int m_sf = 0;
  bit ts_seen = 1'b0;
  bit multihot = 1'b0;

  t2mi_pkt_scheduler #(.BBF_PER_FRAME(BBF), .FRAMES_PER_SF(FPS)) dut (
    .CLK(CLK), .RST(RST), .FRAME_START(frame_start), .TS_REQ(ts_req), .L1_REQ(l1_req),
    .BB_REQ(bb_req), .PKT_DONE(pkt_done), .GRANT(GRANT), .PKT_TYPE(PKT_TYPE),
    .FRAME_IDX(FRAME_IDX), .SF_IDX(SF_IDX), .BUSY(BUSY),
    .ERR_OVERRUN(ERR_OVERRUN), .ERR_UNDERRUN(ERR_UNDERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (GRANT[2] === 1'b1) ts_seen = 1'b1;
    if (!$onehot0(GRANT)) multihot = 1'b1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv_model();
    if (m_idx == FPS - 1) begin
      m_idx = 0;
      m_sf  = (m_sf + 1) % 16;
    end else begin
      m_idx = m_idx + 1;
    end
  endtask

  // Holds the grant 10 cycles, then pulses PKT_DONE (optionally with FRAME_START).
  task automatic serve(input logic [2:0] g, input logic [7:0] t, input bit fs);
    check("grant_on", 32'(GRANT), 32'(g));
    check("pkt_type", 32'(PKT_TYPE), 32'(t));
    repeat (9) tick();
    check("grant_held", 32'(GRANT), 32'(g));
    pkt_done = 1'b1;
    frame_start = fs;
    tick();
    pkt_done = 1'b0;
    frame_start = 1'b0;
    check("grant_off", 32'(GRANT), 32'd0);
  endtask

  // Entered one cycle after FRAME_START was sampled (scheduler in its first WAIT state).
  task automatic frame_body(input int l1_delay, input bit fs_last);
    check("busy_start", 32'(BUSY), 32'd1);
    check("frame_idx", 32'(FRAME_IDX), 32'(m_idx));
    check("sf_idx", 32'(SF_IDX), 32'(m_sf));
    if (TS && m_idx == 0) begin
      tick();
      serve(3'b100, 8'h20, 1'b0);
    end
    for (int i = 0; i < l1_delay; i++) begin
      tick();
      check("l1_wait_nogrant", 32'(GRANT), 32'd0);
    end
    l1_req = 1'b1;
    tick();
    serve(3'b010, 8'h10, 1'b0);
    check("idx_stable", 32'(FRAME_IDX), 32'(m_idx));
    for (int b = 0; b < BBF; b++) begin
      tick();
      serve(3'b001, 8'h00, fs_last && (b == BBF - 1));
    end
    adv_model();
    check("busy_end", 32'(BUSY), 32'(fs_last));
    check("no_overrun", 32'(ERR_OVERRUN), 32'd0);
    check("no_underrun", 32'(ERR_UNDERRUN), 32'd0);
    check("frame_idx_adv", 32'(FRAME_IDX), 32'(m_idx));
    check("sf_idx_adv", 32'(SF_IDX), 32'(m_sf));
  endtask

  task automatic run_frame(input int l1_delay, input bit fs_last);
    l1_req = (l1_delay == 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    frame_body(l1_delay, fs_last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    frame_start = 1'b0; pkt_done = 1'b0;
    ts_req = 1'b1; l1_req = 1'b1; bb_req = 1'b1;
    repeat (2) tick();
    check("rst_grant", 32'(GRANT), 32'd0);
    check("rst_type", 32'(PKT_TYPE), 32'h00);
    check("rst_fidx", 32'(FRAME_IDX), 32'd0);
    check("rst_sfidx", 32'(SF_IDX), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ovr", 32'(ERR_OVERRUN), 32'd0);
    check("rst_und", 32'(ERR_UNDERRUN), 32'd0);
    RST = 1'b0;
    tick();

    // PKT_DONE while idle has no effect
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    check("idle_done_busy", 32'(BUSY), 32'd0);
    check("idle_done_grant", 32'(GRANT), 32'd0);

    // Frame 0: TS (if built), L1, BB x3; then frame index 1
    run_frame(0, 1'b0);
    check("t1_fidx_one", 32'(FRAME_IDX), 32'd1);

    // Three more frames: indices 1/0, 0/1, 1/1
    run_frame(0, 1'b0);
    run_frame(0, 1'b0);
    run_frame(0, 1'b0);
    check("t2_sf_two", 32'(SF_IDX), 32'd2);
    check("t2_fidx_zero", 32'(FRAME_IDX), 32'd0);

    // L1 source stalls for 20 cycles
    run_frame(20, 1'b0);

    // FRAME_START during second BB packet of frame (1,2)
    l1_req = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("ov_busy", 32'(BUSY), 32'd1);
    tick();
    serve(3'b010, 8'h10, 1'b0);
    tick();
    serve(3'b001, 8'h00, 1'b0);
    tick();
    check("ov_bb2_grant", 32'(GRANT), 32'b001);
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("ov_overrun_pulse", 32'(ERR_OVERRUN), 32'd1);
    check("ov_underrun_pulse", 32'(ERR_UNDERRUN), 32'd1);
    check("ov_grant_kept", 32'(GRANT), 32'b001);
    tick();
    check("ov_overrun_clr", 32'(ERR_OVERRUN), 32'd0);
    check("ov_underrun_clr", 32'(ERR_UNDERRUN), 32'd0);
    check("ov_grant_kept2", 32'(GRANT), 32'b001);
    check("ov_idx_held", 32'(FRAME_IDX), 32'(m_idx));
    repeat (3) tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    check("ov_grant_drop", 32'(GRANT), 32'd0);
    check("ov_no_err", 32'(ERR_OVERRUN), 32'd0);
    adv_model();
    check("ov_fidx_once", 32'(FRAME_IDX), 32'd0);
    check("ov_sfidx_once", 32'(SF_IDX), 32'd3);
    frame_body(0, 1'b0);

    // Asynchronous reset in the middle of a BB packet
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    serve(3'b010, 8'h10, 1'b0);
    tick();
    check("rs_bb_grant", 32'(GRANT), 32'b001);
    tick();
    #2;
    RST = 1'b1;
    #1;
    check("rs_grant_async", 32'(GRANT), 32'd0);
    check("rs_fidx", 32'(FRAME_IDX), 32'd0);
    check("rs_sfidx", 32'(SF_IDX), 32'd0);
    check("rs_busy", 32'(BUSY), 32'd0);
    tick();
    RST = 1'b0;
    m_idx = 0;
    m_sf = 0;

    // Restart after reset; last BB done coincides with next FRAME_START (no errors)
    run_frame(0, 1'b1);
    frame_body(0, 1'b0);

    // Run through superframe index wrap 15 -> 0
    for (int f = 0; f < 30; f++) run_frame(0, 1'b0);
    check("sf_wrap_idx", 32'(SF_IDX), 32'd0);
    check("sf_wrap_fidx", 32'(FRAME_IDX), 32'd0);

    check("ts_grant_seen", 32'(ts_seen), 32'(TS));
    check("grant_onehot", 32'(multihot), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
